// File: rtl/servo_pwm_gen.sv
// 50 Hz hobby-servo pulse generator: angle strobe -> target width, applied at period wraps.
// Define SERVO_SLEW_EN to limit the width change per period to SLEW_US; otherwise the target applies in full at the next wrap.
module servo_pwm_gen #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int PERIOD_US  = 20000,
  parameter int MIN_US     = 500,
  parameter int STEP_US    = 11,
  parameter int SLEW_US    = 10,
  parameter int INIT_ANGLE = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] angle,
  input  logic       angle_valid,
  output logic       pwm_out,
  output logic       period_start,
  output logic       busy
);

  localparam int               DIV     = CLK_FREQ / 1_000_000;
  localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [14:0]      CNT_MAX = 15'(PERIOD_US - 1);
  localparam logic [11:0]      INIT_W  = 12'(MIN_US + INIT_ANGLE * STEP_US);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [14:0]      cnt_q, cnt_d;
  logic [11:0]      tgt_w_q, tgt_w_d;
  logic [11:0]      cur_w_q, cur_w_d;
  logic             pwm_q, pwm_d;
  logic             us_tick, wrap;

  // Clamp to 180 degrees before scaling; the 11-bit product is zero-extended so the sum cannot truncate.
  function automatic logic [11:0] angle_to_width(input logic [7:0] a);
    logic [7:0]  ang_c;
    logic [10:0] prod;
    ang_c = (a > 8'd180) ? 8'd180 : a;
    prod  = 11'(32'(ang_c) * STEP_US);
    return 12'(MIN_US) + {1'b0, prod};
  endfunction

`ifdef SERVO_SLEW_EN
  localparam logic [11:0] SLEW_W = 12'(SLEW_US);

  function automatic logic [11:0] slew_step(input logic [11:0] cur, input logic [11:0] tgt);
    logic [11:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff <= SLEW_W) ? tgt : cur + SLEW_W;
    end
    diff = cur - tgt;
    return (diff <= SLEW_W) ? tgt : cur - SLEW_W;
  endfunction
`endif

  always_comb begin
    us_tick = (pre_q == PRE_MAX);
    wrap    = us_tick && (cnt_q == CNT_MAX);
    pre_d   = us_tick ? '0 : pre_q + PRE_W'(1);
    cnt_d   = cnt_q;
    if (us_tick) cnt_d = wrap ? 15'd0 : cnt_q + 15'd1;
    tgt_w_d = angle_valid ? angle_to_width(angle) : tgt_w_q;
    // The width step at a wrap always uses the target held before any coincident strobe.
    cur_w_d = cur_w_q;
    if (wrap) begin
`ifdef SERVO_SLEW_EN
      cur_w_d = slew_step(cur_w_q, tgt_w_q);
`else
      cur_w_d = tgt_w_q;
`endif
    end
    pwm_d = (cnt_q < {3'b000, cur_w_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      tgt_w_q <= INIT_W;
      cur_w_q <= INIT_W;
      pwm_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tgt_w_q <= tgt_w_d;
      cur_w_q <= cur_w_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = wrap;
  assign busy         = (cur_w_q != tgt_w_q);

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen with scaled-down parameters (2 clk/us, 200 us period, 1 us/degree, 20 us slew).
// Each table row is one PWM period: optional angle strobe, expected high clocks, period length and busy at the wrap.
module tb_servo_pwm_gen;
  localparam int CLK_FREQ   = 2_000_000;
  localparam int PERIOD_US  = 200;
  localparam int MIN_US     = 5;
  localparam int STEP_US    = 1;
  localparam int SLEW_US    = 20;
  localparam int INIT_ANGLE = 90;
  localparam int PER        = 400;
  localparam int NV         = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] angle = 8'd0;
  logic       angle_valid = 1'b0;
  logic       pwm_out, period_start, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int off;
    int ang;
    int exp_high;
    int exp_len;
    int exp_busy;
  } vec_t;

  localparam int OFF_A[NV] = '{-1, 100, -1, -1, -1, -1, -1, 50, 10, -1, -1, -1, -1,
                               -1, -1, -1, -1, -1, 10, 399, -1, -1, -1, 10, -1};
  localparam int ANG_A[NV] = '{0, 180, 0, 0, 0, 0, 0, 255, 0, 0, 0, 0, 0,
                               0, 0, 0, 0, 0, 40, 0, 0, 0, 0, 180, 0};
`ifdef SERVO_SLEW_EN
  localparam int HI_A[NV]  = '{190, 190, 230, 270, 310, 350, 370, 370, 370, 330, 290, 250, 210,
                               170, 130, 90, 50, 10, 10, 50, 90, 50, 10, 10, 50};
  localparam int BZ_A[NV]  = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1,
                               1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
`else
  localparam int HI_A[NV]  = '{190, 190, 370, 370, 370, 370, 370, 370, 370, 10, 10, 10, 10,
                               10, 10, 10, 10, 10, 10, 90, 90, 10, 10, 10, 370};
  localparam int BZ_A[NV]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,
                               0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0};
`endif

  vec_t tbl[NV];

  servo_pwm_gen #(
    .CLK_FREQ(CLK_FREQ), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
    .STEP_US(STEP_US), .SLEW_US(SLEW_US), .INIT_ANGLE(INIT_ANGLE)
  ) dut (
    .clk(clk), .rst(rst), .angle(angle), .angle_valid(angle_valid),
    .pwm_out(pwm_out), .period_start(period_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts one period from the next cycle up to and including the cycle where period_start is high.
  task automatic run_period(input int off, input int ang, output int high, output int len, output int bsy);
    high = 0;
    len  = 0;
    bsy  = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      angle_valid = 1'b0;
      if (pwm_out === 1'b1) high++;
      len++;
      if (i == off) begin
        angle       = 8'(ang);
        angle_valid = 1'b1;
      end
      if (period_start === 1'b1) begin
        bsy = (busy === 1'b1) ? 1 : 0;
        return;
      end
    end
    len = -1;
  endtask

  initial begin
    int h, l, b;
    for (int i = 0; i < NV; i++)
      tbl[i] = '{OFF_A[i], ANG_A[i], HI_A[i], (i == 0) ? PER - 1 : PER, BZ_A[i]};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", {31'd0, pwm_out}, 32'd0);
    check("rst_pstart", {31'd0, period_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_period(tbl[i].off, tbl[i].ang, h, l, b);
      check($sformatf("per%0d_high", i), h, tbl[i].exp_high);
      check($sformatf("per%0d_len", i), l, tbl[i].exp_len);
      check($sformatf("per%0d_busy", i), b, tbl[i].exp_busy);
    end

    repeat (20) @(negedge clk);
    check("mid_pulse_high", {31'd0, pwm_out}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm", {31'd0, pwm_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pstart", {31'd0, period_start}, 32'd0);
    rst = 1'b0;
    run_period(-1, 0, h, l, b);
    check("postrst_high", h, 190);
    check("postrst_len", l, PER - 1);
    check("postrst_busy", b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
